// File: rtl/axi4lite_sram_slave_if.sv
// AXI4-lite bus bundle between the core's memory master port and the SRAM slave.
// Also carries read-only FSM state taps so checkers can bind without reaching into the design.
interface axi4lite_sram_slave_if;
  // Valid/ready: a transfer happens on a rising clk edge where both valid and ready are 1.
  // A source holds valid and its payload steady until that edge. The slave's ready and
  // response valids are registered and never depend combinationally on master outputs.
  logic        mem_axi_awvalid;
  logic        mem_axi_awready;
  logic [31:0] mem_axi_awaddr;
  logic [2:0]  mem_axi_awprot;
  logic        mem_axi_wvalid;
  logic        mem_axi_wready;
  logic [31:0] mem_axi_wdata;
  logic [3:0]  mem_axi_wstrb;
  logic        mem_axi_bvalid;
  logic        mem_axi_bready;
  logic        mem_axi_arvalid;
  logic        mem_axi_arready;
  logic [31:0] mem_axi_araddr;
  logic [2:0]  mem_axi_arprot;
  logic        mem_axi_rvalid;
  logic        mem_axi_rready;
  logic [31:0] mem_axi_rdata;
  logic [1:0]  dbg_wr_state;
  logic [1:0]  dbg_rd_state;

  modport master (
    output mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
    output mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
    output mem_axi_bready,
    output mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
    output mem_axi_rready,
    input  mem_axi_awready, mem_axi_wready, mem_axi_bvalid,
    input  mem_axi_arready, mem_axi_rvalid, mem_axi_rdata,
    input  dbg_wr_state, dbg_rd_state
  );

  modport slave (
    input  mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
    input  mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
    input  mem_axi_bready,
    input  mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
    input  mem_axi_rready,
    output mem_axi_awready, mem_axi_wready, mem_axi_bvalid,
    output mem_axi_arready, mem_axi_rvalid, mem_axi_rdata,
    output dbg_wr_state, dbg_rd_state
  );
endinterface

// File: rtl/axi4lite_sram_slave.sv
// AXI4-lite word-addressed SRAM slave with independent read/write channels,
// programmable wait states and a sticky out-of-range error flag.
module axi4lite_sram_slave #(
  parameter int          MEM_WORDS = 16384,
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int          RD_WAIT   = 0,
  parameter int          WR_WAIT   = 0
) (
  input  logic                 clk,
  input  logic                 resetn,
  axi4lite_sram_slave_if.slave bus,
  input  logic                 clear_err,
  output logic                 oob_err,
  output logic [31:0]          oob_addr
);

  localparam int          AW = $clog2(MEM_WORDS);
  localparam logic [32:0] LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] HI = LO + (33'(MEM_WORDS) << 2);

  typedef enum logic [1:0] {W_COLLECT = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} r_state_t;

  // Compare in 33 bits so the top of the window cannot wrap past 2^32.
  function automatic logic in_range(input logic [31:0] a);
    return ({1'b0, a} >= LO) && ({1'b0, a} < HI);
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  logic [31:0] mem [MEM_WORDS];

  w_state_t    w_state;
  logic [3:0]  w_cnt;
  logic        aw_full, w_full;
  logic [31:0] aw_addr, w_data;
  logic [3:0]  w_strb;
  logic        awready_q, wready_q, bvalid_q;

  r_state_t    r_state;
  logic [3:0]  r_cnt;
  logic [31:0] ar_addr, rdata_q;
  logic        arready_q, rvalid_q;

  logic aw_take, w_take, aw_full_n, w_full_n, commit, wr_ok;
  logic ar_take, rd_load, rd_err, wr_err;

  assign aw_take   = (w_state == W_COLLECT) && awready_q && bus.mem_axi_awvalid;
  assign w_take    = (w_state == W_COLLECT) && wready_q && bus.mem_axi_wvalid;
  assign aw_full_n = aw_full | aw_take;
  assign w_full_n  = w_full | w_take;
  assign commit    = (w_state == W_WAIT) && (w_cnt == 4'd0);
  assign wr_ok     = in_range(aw_addr);

  assign ar_take   = (r_state == R_IDLE) && arready_q && bus.mem_axi_arvalid;
  assign rd_load   = (r_state == R_WAIT) && (r_cnt == 4'd0);
  assign rd_err    = ar_take && !in_range(bus.mem_axi_araddr);
  assign wr_err    = commit && !wr_ok;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state   <= W_COLLECT;
      w_cnt     <= 4'd0;
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      aw_addr   <= 32'h0;
      w_data    <= 32'h0;
      w_strb    <= 4'h0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      case (w_state)
        W_COLLECT: begin
          if (aw_take) aw_addr <= bus.mem_axi_awaddr;
          if (w_take) begin
            w_data <= bus.mem_axi_wdata;
            w_strb <= bus.mem_axi_wstrb;
          end
          aw_full <= aw_full_n;
          w_full  <= w_full_n;
          if (aw_full_n && w_full_n) begin
            w_state   <= W_WAIT;
            w_cnt     <= 4'(WR_WAIT);
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
          end else begin
            awready_q <= !aw_full_n;
            wready_q  <= !w_full_n;
          end
        end
        W_WAIT: begin
          if (w_cnt == 4'd0) begin
            w_state  <= W_RESP;
            bvalid_q <= 1'b1;
          end else begin
            w_cnt <= w_cnt - 4'd1;
          end
        end
        W_RESP: begin
          if (bus.mem_axi_bready) begin
            bvalid_q  <= 1'b0;
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            w_state   <= W_COLLECT;
          end
        end
        default: w_state <= W_COLLECT;
      endcase
    end
  end

  // Storage is deliberately outside reset so contents survive a core reset.
  always_ff @(posedge clk) begin
    if (commit && wr_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb[b]) mem[word_idx(aw_addr)][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= R_IDLE;
      r_cnt     <= 4'd0;
      ar_addr   <= 32'h0;
      rdata_q   <= 32'h0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_take) begin
            ar_addr   <= bus.mem_axi_araddr;
            r_cnt     <= 4'(RD_WAIT);
            arready_q <= 1'b0;
            r_state   <= R_WAIT;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_WAIT: begin
          if (r_cnt == 4'd0) begin
            // Non-blocking read gives the pre-write word on a same-cycle commit.
            rdata_q  <= in_range(ar_addr) ? mem[word_idx(ar_addr)] : 32'h0;
            rvalid_q <= 1'b1;
            r_state  <= R_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        R_RESP: begin
          if (bus.mem_axi_rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            r_state   <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // A new error outranks clear_err; only the first address since clear is kept.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      oob_err  <= 1'b0;
      oob_addr <= 32'h0;
    end else if (rd_err || wr_err) begin
      oob_err <= 1'b1;
      if (!oob_err) oob_addr <= rd_err ? bus.mem_axi_araddr : aw_addr;
    end else if (clear_err) begin
      oob_err  <= 1'b0;
      oob_addr <= 32'h0;
    end
  end

  assign bus.mem_axi_awready = awready_q;
  assign bus.mem_axi_wready  = wready_q;
  assign bus.mem_axi_bvalid  = bvalid_q;
  assign bus.mem_axi_arready = arready_q;
  assign bus.mem_axi_rvalid  = rvalid_q;
  assign bus.mem_axi_rdata   = rdata_q;
  assign bus.dbg_wr_state    = w_state;
  assign bus.dbg_rd_state    = r_state;

  logic unused_bits;
  assign unused_bits = ^{bus.mem_axi_awprot, bus.mem_axi_arprot, rd_load};

endmodule

// File: doc/axi4lite_sram_slave.md
Name: axi4lite_sram_slave

Overview:
- AXI4-lite slave memory sitting directly downstream of the core's AXI4-lite master port; serves instruction fetches and data loads/stores.
- Read and write channels are independent. Each channel has a programmable wait-state count.
- Word-addressed storage is mapped at BASE_ADDR, so the core's reset vector 0x10000 fetches from word 0.
- Out-of-range accesses are reported on a sticky error flag, because this master interface carries no BRESP/RRESP.

Parameters:
- MEM_WORDS, 16384, number of 32-bit words of storage; power of two, minimum 4.
- BASE_ADDR, 32'h0001_0000, byte address of word 0; aligned to 4*MEM_WORDS.
- RD_WAIT, 0, extra cycles between AR acceptance and RVALID; range 0..15.
- WR_WAIT, 0, extra cycles between holding both AW and W and BVALID; range 0..15.

Ports:
- clk  in  1  clock; all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- mem_axi_awvalid  in  1  write address valid.
- mem_axi_awready  out  1  write address ready.
- mem_axi_awaddr  in  32  write byte address.
- mem_axi_awprot  in  3  ignored.
- mem_axi_wvalid  in  1  write data valid.
- mem_axi_wready  out  1  write data ready.
- mem_axi_wdata  in  32  write data.
- mem_axi_wstrb  in  4  byte enables; bit i covers wdata[8i+7:8i].
- mem_axi_bvalid  out  1  write response valid.
- mem_axi_bready  in  1  write response ready.
- mem_axi_arvalid  in  1  read address valid.
- mem_axi_arready  out  1  read address ready.
- mem_axi_araddr  in  32  read byte address.
- mem_axi_arprot  in  3  ignored.
- mem_axi_rvalid  out  1  read data valid.
- mem_axi_rready  in  1  read data ready.
- mem_axi_rdata  out  32  read data.
- clear_err  in  1  synchronous clear of oob_err/oob_addr.
- oob_err  out  1  sticky: an out-of-range access occurred.
- oob_addr  out  32  byte address of the first out-of-range access since last clear.

Behaviour:
- Reset (resetn=0, asynchronous): all readies, bvalid, rvalid, oob_err = 0; rdata = 0; oob_addr = 0; both FSMs go to IDLE; wait counters = 0; AW/W holding registers are marked empty.
  - Memory array is not reset; its contents are retained across reset.
  - Reset asserted mid-transaction abandons the transaction. A pending write whose commit cycle has not occurred is not performed.
- Address decode: word index = (addr - BASE_ADDR) >> 2.
  - addr[1:0] are ignored.
  - In range iff BASE_ADDR <= addr < BASE_ADDR + 4*MEM_WORDS, computed in 33 bits (no wrap).
- Write path, states W_COLLECT, W_WAIT, W_RESP:
  - W_COLLECT: awready=1 while the AW holding register is empty; wready=1 while the W holding register is empty. Each captures on its own valid&ready, in either order or the same cycle.
  - W_COLLECT -> W_WAIT: when both AW and W are held; the counter loads WR_WAIT.
  - W_WAIT: the counter decrements each cycle. At 0 comes the commit cycle: an in-range write updates only the strobed bytes; an out-of-range write is dropped. Then go to W_RESP.
  - W_RESP: bvalid=1 from the cycle after commit, held until bready. On the handshake, both holding registers empty and the FSM returns to W_COLLECT. awready/wready reassert the following cycle.
  - Minimum latency with WR_WAIT=0: last of AW/W accepted at cycle N, commit at N+1, bvalid at N+2.
  - wstrb=0 is a legal no-op write and still produces a B response.
- Read path, states R_IDLE, R_WAIT, R_RESP:
  - R_IDLE: arready=1; on arvalid, capture the address, load the counter with RD_WAIT, go to R_WAIT.
  - R_WAIT: the counter decrements. At 0, rdata is loaded from memory (in range) or with 32'h0 (out of range); go to R_RESP.
  - R_RESP: rvalid=1. rdata is stable until rready; on the handshake return to R_IDLE, and arready reasserts the next cycle.
  - RD_WAIT=0 latency: AR accepted at N, rvalid at N+2.
- Read/write collision: a read capture and a write commit to the same word in the same cycle return the pre-write value (read-before-write). A read loaded on any later cycle sees the new data.
- Error flag:
  - oob_err sets on the cycle an out-of-range AR is accepted or an out-of-range write commits.
  - oob_addr latches only if oob_err was 0. If read and write are both out of range in the same cycle, the read address wins.
  - clear_err=1 clears both next cycle; a simultaneous new error takes priority and sets/latches.
- Handshake rules:
  - Outputs never depend combinationally on inputs; all are registered.
  - bvalid/rvalid, once high, never drop before their ready.
  - Each channel allows at most one outstanding transaction.

Test Plan:
- Reset, then AR 0x10000 with RD_WAIT=0, rready=1, preloaded word0=0x00000013 -> rvalid at AR+2 with rdata=0x00000013; arready back at 1 the cycle after the R handshake.
- W (0xAABBCCDD, wstrb=4'b0101) two cycles before AW 0x10004, old word1=0x11223344 -> awready stays 1 and wready drops after W capture; bvalid at AW+2; subsequent read of 0x10004 returns 0x11BB33DD.
- RD_WAIT=3, WR_WAIT=2, rready/bready held low 5 cycles -> rvalid at AR+5 and bvalid at commit+1; both stay high with rdata constant until ready; no second AR/AW accepted meanwhile.
- Same-cycle read capture and write commit to 0x10008 (old 0x0, new 0xCAFEF00D) -> read returns 0x0; next read returns 0xCAFEF00D.
- Read 0x0000FFFC, then write 0x00050000 -> rdata=0x0, bvalid still issued, memory unchanged; oob_err=1, oob_addr=0x0000FFFC; clear_err -> both 0 next cycle.
- resetn pulsed low while in W_WAIT for 0x1000C (old 0x5) -> bvalid=0 immediately, word 0x1000C still reads 0x5 after reset, all readies return to idle values.
